// File: rtl/max11100_emulator_if.sv
// Pin-level bundle for the MAX11100 SPI slave emulator: sample loading side and SPI side.
interface max11100_emulator_if;
    logic [15:0] i_sample;
    logic        i_sample_valid;
    logic        i_sclk;
    logic        i_cs_n;
    logic        o_miso;
    logic        o_miso_oe;
    logic        o_busy;
    logic        o_frame_done;
    logic        o_short_frame;

    modport slave (
        input  i_sample, i_sample_valid, i_sclk, i_cs_n,
        output o_miso, o_miso_oe, o_busy, o_frame_done, o_short_frame
    );

    modport master (
        output i_sample, i_sample_valid, i_sclk, i_cs_n,
        input  o_miso, o_miso_oe, o_busy, o_frame_done, o_short_frame
    );
endinterface

// File: rtl/max11100_emulator.sv
// SPI mode-0 slave that serves 24-bit frames {8'h00, sample} like a MAX11100 ADC,
// oversampling the asynchronous SCLK/CS pins with the system clock.
module max11100_emulator (
    input  logic                  i_clk,
    input  logic                  i_rst,
    max11100_emulator_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t      state;
    state_t      state_next;

    logic        cs_meta, cs_sync, cs_prev;
    logic        sclk_meta, sclk_sync, sclk_prev;
    logic        cs_fall, cs_rise, cs_edge;
    logic        sclk_rise, sclk_fall;

    logic [15:0] hold_reg;
    logic [23:0] shift_reg;
    logic [4:0]  bit_cnt;

    logic        load;
    logic        count_en;
    logic        shift_en;
    logic        frame_done, frame_done_next;
    logic        short_frame, short_frame_next;

    // Reset to 0 so a CS held low through reset never looks like a falling edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cs_meta   <= 1'b0;
            cs_sync   <= 1'b0;
            cs_prev   <= 1'b0;
            sclk_meta <= 1'b0;
            sclk_sync <= 1'b0;
            sclk_prev <= 1'b0;
        end else begin
            cs_meta   <= bus.i_cs_n;
            cs_sync   <= cs_meta;
            cs_prev   <= cs_sync;
            sclk_meta <= bus.i_sclk;
            sclk_sync <= sclk_meta;
            sclk_prev <= sclk_sync;
        end
    end

    assign cs_fall   = cs_prev & ~cs_sync;
    assign cs_rise   = ~cs_prev & cs_sync;
    assign cs_edge   = cs_fall | cs_rise;
    assign sclk_rise = ~sclk_prev & sclk_sync;
    assign sclk_fall = sclk_prev & ~sclk_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next       = state;
        load             = 1'b0;
        count_en         = 1'b0;
        shift_en         = 1'b0;
        frame_done_next  = 1'b0;
        short_frame_next = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_next = SHIFT;
                    load       = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_next       = IDLE;
                    short_frame_next = 1'b1;
                end else if (!cs_edge) begin
                    // Falling edge before the first rising edge carries no bit boundary.
                    if (sclk_rise) begin
                        count_en = 1'b1;
                        if (bit_cnt == 5'd23) begin
                            state_next = HOLD;
                        end
                    end else if (sclk_fall && bit_cnt != 5'd0) begin
                        shift_en = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (cs_rise) begin
                    state_next      = IDLE;
                    frame_done_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hold_reg    <= '0;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            frame_done  <= 1'b0;
            short_frame <= 1'b0;
        end else begin
            if (bus.i_sample_valid) begin
                hold_reg <= bus.i_sample;
            end
            if (load) begin
                shift_reg <= {8'h00, hold_reg};
            end else if (shift_en) begin
                shift_reg <= {shift_reg[22:0], 1'b0};
            end
            if (load) begin
                bit_cnt <= '0;
            end else if (count_en) begin
                bit_cnt <= bit_cnt + 5'd1;
            end
            frame_done  <= frame_done_next;
            short_frame <= short_frame_next;
        end
    end

    always_comb begin
        bus.o_miso        = (state == SHIFT) ? shift_reg[23] : 1'b0;
        bus.o_miso_oe     = (state != IDLE);
        bus.o_busy        = (state != IDLE);
        bus.o_frame_done  = frame_done;
        bus.o_short_frame = short_frame;
    end

endmodule
